// File: rtl/demux_capture8.sv
// demux_capture8: reassembles one frame from the eight outputs of an upstream
// 1:8 demux, and hands the frame to a consumer through a valid/ready output.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   y[7:0]      demultiplexed data from the upstream demux
//   e_in        upstream demux enable (one channel written this cycle)
//   s_in[2:0]   upstream demux channel select
//   out_ready   consumer accepts out_data when out_valid is also 1
//   clr_err     synchronous clear of the sticky error flags
//   out_data    last completed frame (bit k = channel k)
//   out_valid   out_data holds an unconsumed frame
//   fill_mask   channels already captured in the frame being collected
//   frame_cnt   frames accepted by the consumer, wraps at 256
//   err_ovf     sticky: completed frame dropped, output still occupied
//   err_dup     sticky: a channel was written twice within one frame
//   err_glitch  sticky: y had a bit set outside the selected channel
module demux_capture8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y,
    input  logic       e_in,
    input  logic [2:0] s_in,
    input  logic       out_ready,
    input  logic       clr_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [7:0] fill_mask,
    output logic [7:0] frame_cnt,
    output logic       err_ovf,
    output logic       err_dup,
    output logic       err_glitch
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] shadow_q;
    logic [7:0] fill_q;
    logic [7:0] data_q;
    logic [7:0] cnt_q;
    logic       valid_q;
    logic       ovf_q;
    logic       dup_q;
    logic       glitch_q;

    logic [7:0] onehot;
    logic [7:0] shadow_d;
    logic [7:0] fill_d;
    logic       complete;
    logic       dup_ev;
    logic       glitch_ev;
    logic       ovf_ev;

    // Capture path. shadow_d already carries this edge's bit, so a frame
    // that completes on this edge is loaded from shadow_d, not shadow_q.
    always_comb begin
        onehot    = 8'd1 << s_in;
        shadow_d  = shadow_q;
        fill_d    = fill_q;
        complete  = 1'b0;
        dup_ev    = 1'b0;
        glitch_ev = 1'b0;
        if (e_in) begin
            shadow_d  = (shadow_q & ~onehot) | (y & onehot);
            dup_ev    = |(fill_q & onehot);
            glitch_ev = |(y & ~onehot);
            complete  = ((fill_q | onehot) == 8'hFF);
            fill_d    = complete ? 8'h00 : (fill_q | onehot);
        end
        ovf_ev = complete && (state_q == HOLD) && !out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            shadow_q <= 8'h00;
            fill_q   <= 8'h00;
            data_q   <= 8'h00;
            cnt_q    <= 8'h00;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dup_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            fill_q   <= fill_d;
            // A new error event wins over a simultaneous clear.
            ovf_q    <= (ovf_q & ~clr_err) | ovf_ev;
            dup_q    <= (dup_q & ~clr_err) | dup_ev;
            glitch_q <= (glitch_q & ~clr_err) | glitch_ev;
            unique case (state_q)
                COLLECT: begin
                    if (complete) begin
                        data_q  <= shadow_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Without out_ready a completing frame is dropped
                    // (flagged through ovf_ev above).
                    if (out_ready) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (complete) begin
                            data_q <= shadow_d;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= COLLECT;
                        end
                    end
                end
            endcase
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fill_mask  = fill_q;
    assign frame_cnt  = cnt_q;
    assign err_ovf    = ovf_q;
    assign err_dup    = dup_q;
    assign err_glitch = glitch_q;

endmodule

// File: tb/tb_demux_capture8.sv
// tb_demux_capture8: directed scenario bench for demux_capture8.
// Each task drives one scenario and checks outputs inline.
module tb_demux_capture8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] y = 8'h00;
    logic       e_in = 1'b0;
    logic [2:0] s_in = 3'd0;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] fill_mask;
    logic [7:0] frame_cnt;
    logic       err_ovf;
    logic       err_dup;
    logic       err_glitch;

    int n_cmp = 0;
    int n_err = 0;

    demux_capture8 dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .e_in      (e_in),
        .s_in      (s_in),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fill_mask (fill_mask),
        .frame_cnt (frame_cnt),
        .err_ovf   (err_ovf),
        .err_dup   (err_dup),
        .err_glitch(err_glitch)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        e_in = 1'b0;
        clr_err = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_ch(input logic [2:0] s, input logic d);
        e_in = 1'b1;
        s_in = s;
        y = 8'(d) << s;
        tick();
        e_in = 1'b0;
        y = 8'h00;
    endtask

    task automatic write_frame(input logic [7:0] f);
        for (int i = 0; i < 8; i++) write_ch(3'(i), f[i]);
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        write_ch(3'd1, 1'b1);
        rst = 1'b1;
        e_in = 1'b1;
        y = 8'hFF;
        tick();
        rst = 1'b0;
        e_in = 1'b0;
        y = 8'h00;
        n_cmp++;
        if ({out_data, out_valid, fill_mask, frame_cnt} !== 25'h0) begin
            n_err++;
            $display("FAIL reset_state got %h/%b/%h/%h want 0", out_data,
                     out_valid, fill_mask, frame_cnt);
        end
        n_cmp++;
        if ({err_ovf, err_dup, err_glitch} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_errs got %b want 000",
                     {err_ovf, err_dup, err_glitch});
        end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'h4D;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) write_ch(3'(i), pat[i]);
        n_cmp++;
        if (fill_mask !== 8'h07) begin
            n_err++;
            $display("FAIL basic_fill got %h want 07", fill_mask);
        end
        // Idle with garbage on y: nothing captured, out_ready in COLLECT ignored.
        y = 8'hFF;
        tick();
        y = 8'h00;
        n_cmp++;
        if (fill_mask !== 8'h07 || frame_cnt !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle got %h/%h/%b want 07/00/0", fill_mask,
                     frame_cnt, out_valid);
        end
        for (int i = 3; i < 8; i++) write_ch(3'(i), pat[i]);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h4D || fill_mask !== 8'h00) begin
            n_err++;
            $display("FAIL basic_frame got %b/%h/%h want 1/4d/00", out_valid,
                     out_data, fill_mask);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'h01) begin
            n_err++;
            $display("FAIL basic_accept got %b/%h want 0/01", out_valid, frame_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        write_frame(8'hFF);
        write_frame(8'h00);
        n_cmp++;
        if (out_data !== 8'hFF || err_ovf !== 1'b1 || out_valid !== 1'b1 ||
            fill_mask !== 8'h00) begin
            n_err++;
            $display("FAIL ovf_hold got %h/%b/%b/%h want ff/1/1/00", out_data,
                     err_ovf, out_valid, fill_mask);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'h01) begin
            n_err++;
            $display("FAIL ovf_accept got %b/%h want 0/01", out_valid, frame_cnt);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got %b want 0", err_ovf);
        end
    endtask

    task automatic test_dup();
        logic [2:0] seq [9];
        seq = '{3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        do_reset();
        write_ch(seq[0], 1'b1);
        write_ch(seq[1], 1'b1);
        n_cmp++;
        if (err_dup !== 1'b1 || fill_mask !== 8'h08) begin
            n_err++;
            $display("FAIL dup_flag got %b/%h want 1/08", err_dup, fill_mask);
        end
        for (int i = 2; i < 8; i++) write_ch(seq[i], 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || fill_mask !== 8'h7F) begin
            n_err++;
            $display("FAIL dup_8th got %b/%h want 0/7f", out_valid, fill_mask);
        end
        write_ch(seq[8], 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            n_err++;
            $display("FAIL dup_9th got %b/%h want 1/ff", out_valid, out_data);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (err_dup !== 1'b0) begin
            n_err++;
            $display("FAIL dup_clear got %b want 0", err_dup);
        end
        // A duplicate on the same edge as clr_err keeps the flag set.
        write_ch(3'd0, 1'b0);
        clr_err = 1'b1;
        write_ch(3'd0, 1'b0);
        clr_err = 1'b0;
        n_cmp++;
        if (err_dup !== 1'b1) begin
            n_err++;
            $display("FAIL dup_vs_clear got %b want 1", err_dup);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        e_in = 1'b1;
        s_in = 3'd2;
        y = 8'h06;
        tick();
        e_in = 1'b0;
        y = 8'h00;
        n_cmp++;
        if (err_glitch !== 1'b1 || fill_mask !== 8'h04 || err_dup !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_flag got %b/%h/%b want 1/04/0", err_glitch,
                     fill_mask, err_dup);
        end
        for (int i = 0; i < 8; i++)
            if (i != 2) write_ch(3'(i), 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h04) begin
            n_err++;
            $display("FAIL glitch_frame got %b/%h want 1/04", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fb;
        fb = 8'h3C;
        do_reset();
        write_frame(8'hA5);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || frame_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_first got %b/%h/%h want 1/a5/00", out_valid,
                     out_data, frame_cnt);
        end
        for (int i = 0; i < 7; i++) begin
            write_ch(3'(i), fb[i]);
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_valid_%0d got %b want 1", i, out_valid);
            end
        end
        out_ready = 1'b1;
        write_ch(3'd7, fb[7]);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || frame_cnt !== 8'h01 ||
            err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second got %b/%h/%h/%b want 1/3c/01/0", out_valid,
                     out_data, frame_cnt, err_ovf);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'h02) begin
            n_err++;
            $display("FAIL b2b_drain got %b/%h want 0/02", out_valid, frame_cnt);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        write_frame(8'hFF);
        for (int i = 0; i < 5; i++) write_ch(3'(i), 1'b1);
        n_cmp++;
        if (fill_mask !== 8'h1F || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre got %h/%b want 1f/1", fill_mask, out_valid);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (fill_mask !== 8'h00 || out_valid !== 1'b0 || frame_cnt !== 8'h00 ||
            out_data !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_post got %h/%b/%h/%h want 00/0/00/00",
                     fill_mask, out_valid, frame_cnt, out_data);
        end
        for (int i = 0; i < 7; i++) write_ch(3'(i), i == 0);
        n_cmp++;
        if (out_valid !== 1'b0 || fill_mask !== 8'h7F) begin
            n_err++;
            $display("FAIL rstmid_7 got %b/%h want 0/7f", out_valid, fill_mask);
        end
        write_ch(3'd7, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h81) begin
            n_err++;
            $display("FAIL rstmid_frame got %b/%h want 1/81", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'h01) begin
            n_err++;
            $display("FAIL rstmid_cnt got %b/%h want 0/01", out_valid, frame_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_dup();
        test_glitch();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_capture8.md
DEMUX_CAPTURE8 -- requirements
Module: demux_capture8

Interface
REQ-001 The block SHALL have ports: clk input 1, rising-edge clock for all state.
REQ-002 rst input 1 SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-003 y input 8: demultiplexed data from the upstream 1:8 demux.
REQ-004 e_in input 1: the enable that was applied to the upstream demux this cycle; 1 means one channel is being written.
REQ-005 s_in input 3: the channel select that was applied to the upstream demux this cycle.
REQ-006 out_ready input 1: the consumer accepts out_data when out_ready and out_valid are both 1.
REQ-007 clr_err input 1: a synchronous clear of the sticky error flags.
REQ-008 out_data output 8: the assembled frame, where bit k is the value last captured on channel k.
REQ-009 out_valid output 1: out_data holds an unconsumed frame.
REQ-010 fill_mask output 8: a set bit marks a channel already captured in the frame currently being collected.
REQ-011 frame_cnt output 8: the count of frames accepted by the consumer, wrapping 255 to 0.
REQ-012 err_ovf output 1: sticky flag; a completed frame was dropped because the output was still occupied.
REQ-013 err_dup output 1: sticky flag; a channel was written twice within one frame.
REQ-014 err_glitch output 1: sticky flag; y had a bit set other than bit s_in while e_in was 1.

Function
REQ-015 Capture: on each clk edge with e_in=1, shadow[s_in] SHALL take y[s_in] and fill_mask[s_in] SHALL become 1.
REQ-016 y SHALL be ignored when e_in=0, and shadow and fill_mask SHALL hold their values.
REQ-017 Duplicate write: if e_in=1 and fill_mask[s_in] is already 1, shadow[s_in] SHALL be overwritten and err_dup SHALL be set.
REQ-018 Glitch: if e_in=1 and (y AND NOT onehot(s_in)) is not 0, err_glitch SHALL be set; the capture of y[s_in] SHALL still occur.
REQ-019 Frame completion SHALL occur on an edge where e_in=1 and (fill_mask OR onehot(s_in)) equals 8'hFF.
REQ-020 On completion, the completed frame SHALL include the bit captured on that same edge, and fill_mask SHALL clear to 0 on that edge.
REQ-021 The FSM SHALL have two states: COLLECT (out_valid=0) and HOLD (out_valid=1).
REQ-022 COLLECT to HOLD: on completion, out_data SHALL load the completed frame and out_valid SHALL be 1 from the next cycle (1-cycle latency).
REQ-023 HOLD to COLLECT: when out_ready=1 and there is no completion on the same edge, out_valid SHALL go to 0 and frame_cnt SHALL increment by 1.
REQ-024 HOLD with out_ready=1 and a completion on the same edge: the old frame SHALL be accepted (frame_cnt+1), the new frame SHALL load into out_data, and out_valid SHALL stay 1.
REQ-025 HOLD with out_ready=0 and a completion: the new frame SHALL be discarded, out_data SHALL be unchanged, fill_mask SHALL clear, and err_ovf SHALL be set.
REQ-026 Collection into shadow SHALL continue in both states; out_data SHALL change only when a frame loads.
REQ-027 clr_err=1 SHALL clear all three error flags on that edge.
REQ-028 An error event coinciding with clr_err=1 SHALL take priority, leaving that flag set.
REQ-029 out_ready while in COLLECT SHALL have no effect.

Reset
REQ-030 rst=1 SHALL force out_data=0, out_valid=0, fill_mask=0, shadow=0, frame_cnt=0, all error flags to 0, and state COLLECT; rst overrides all other inputs.
REQ-031 rst asserted mid-frame or in HOLD SHALL discard the partial frame and the held frame without incrementing frame_cnt.

Verification
REQ-032 Reset, then e_in=1 with s_in=0..7 in order and y=onehot(s_in)·d for d pattern 1,0,1,1,0,0,1,0; out_ready=1 -> out_data=8'h4D with out_valid=1 for 1 cycle one cycle after the s_in=7 edge, and frame_cnt=1.
REQ-033 Two complete frames (8'hFF then 8'h00) with out_ready=0 throughout -> out_data=8'hFF, err_ovf=1, out_valid=1; then out_ready=1 for 1 cycle -> out_valid=0, frame_cnt=1.
REQ-034 s_in sequence 3,3,0,1,2,4,5,6,7 -> err_dup=1 and the frame completes on the 9th write; clr_err=1 -> err_dup=0.
REQ-035 e_in=1, s_in=2, y=8'h06 -> err_glitch=1, shadow bit 2=1, fill_mask=8'h04.
REQ-036 Back-to-back frames with out_ready=1 on the completion edge of the second -> out_valid stays 1 continuously and frame_cnt increments once per frame.
REQ-037 rst=1 after 5 channels are captured -> fill_mask=0; 8 subsequent writes -> exactly one frame.
